ex_muldiv_ctrl: RTL and testbench

//   Execute-stage sequencer for MIPS MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.

---
 rtl/ex_muldiv_ctrl_if.sv | 28 ++
 rtl/ex_muldiv_ctrl.sv | 152 +++++++++++++++
 tb/tb_ex_muldiv_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_ctrl_if.sv
// HI/LO unit bus: ID/EX instruction fields in, stall/status and HI/LO contents out.
// The pipeline side is the master and the multiply/divide sequencer is the slave.
interface ex_muldiv_ctrl_if #(
  parameter int NB_DATA  = 32,
  parameter int NB_FUNCT = 6
);
  logic                i_valid;
  logic [NB_FUNCT-1:0] i_funct;
  logic [NB_DATA-1:0]  i_data_1;
  logic [NB_DATA-1:0]  i_data_2;
  logic                i_flush;
  logic                o_stall;
  logic                o_busy;
  logic                o_done;
  logic                o_div_by_zero;
  logic [NB_DATA-1:0]  o_hi;
  logic [NB_DATA-1:0]  o_lo;

  modport master (
    output i_valid, i_funct, i_data_1, i_data_2, i_flush,
    input  o_stall, o_busy, o_done, o_div_by_zero, o_hi, o_lo
  );

  modport slave (
    input  i_valid, i_funct, i_data_1, i_data_2, i_flush,
    output o_stall, o_busy, o_done, o_div_by_zero, o_hi, o_lo
  );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// Execute-stage MULT/MULTU/DIV/DIVU sequencer with HI/LO ownership.
// One shift-add or restoring-divide step per cycle on operand magnitudes, sign fix at the end.
module ex_muldiv_ctrl #(
  parameter int NB_DATA  = 32,
  parameter int NB_FUNCT = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  ex_muldiv_ctrl_if.slave   bus
);
  localparam int NB_CNT = $clog2(NB_DATA);

  localparam logic [NB_FUNCT-1:0] F_MFHI  = NB_FUNCT'(6'b010000);
  localparam logic [NB_FUNCT-1:0] F_MTHI  = NB_FUNCT'(6'b010001);
  localparam logic [NB_FUNCT-1:0] F_MFLO  = NB_FUNCT'(6'b010010);
  localparam logic [NB_FUNCT-1:0] F_MTLO  = NB_FUNCT'(6'b010011);
  localparam logic [NB_FUNCT-1:0] F_MULT  = NB_FUNCT'(6'b011000);
  localparam logic [NB_FUNCT-1:0] F_MULTU = NB_FUNCT'(6'b011001);
  localparam logic [NB_FUNCT-1:0] F_DIV   = NB_FUNCT'(6'b011010);
  localparam logic [NB_FUNCT-1:0] F_DIVU  = NB_FUNCT'(6'b011011);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t              state_q, state_d;
  logic [NB_CNT-1:0]   cnt_q;
  logic [NB_DATA-1:0]  hi_q, lo_q;
  logic [NB_DATA-1:0]  op_a_q, op_b_q, acc_q, lo_w_q;
  logic                sign_a_q, sign_b_q, is_div_q, is_signed_q, dz_q;

  function automatic logic [NB_DATA-1:0] neg_w(input logic [NB_DATA-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*NB_DATA-1:0] neg_d(input logic [2*NB_DATA-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic is_muldiv, is_hilo, idle_like, accept, mt_ok, in_signed, in_sign_a, in_sign_b;

  always_comb begin
    is_muldiv = (bus.i_funct == F_MULT) || (bus.i_funct == F_MULTU) ||
                (bus.i_funct == F_DIV)  || (bus.i_funct == F_DIVU);
    is_hilo   = is_muldiv || (bus.i_funct == F_MFHI) || (bus.i_funct == F_MTHI) ||
                (bus.i_funct == F_MFLO) || (bus.i_funct == F_MTLO);
    idle_like = (state_q == IDLE) || (state_q == DONE);
    accept    = idle_like && bus.i_valid && !bus.i_flush && is_muldiv;
    mt_ok     = idle_like && bus.i_valid && !bus.i_flush;
    in_signed = !bus.i_funct[0];
    in_sign_a = in_signed && bus.i_data_1[NB_DATA-1];
    in_sign_b = in_signed && bus.i_data_2[NB_DATA-1];
  end

  // Iteration step: shift-add for multiply, restoring subtract for divide
  logic [NB_DATA:0]   mul_sum;
  logic [NB_DATA:0]   div_trial;
  logic [NB_DATA+1:0] div_diff;
  logic               div_ok;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_w_q[0] ? {1'b0, op_a_q} : '0);
    div_trial = {acc_q, lo_w_q[NB_DATA-1]};
    div_diff  = {1'b0, div_trial} - {2'b00, op_b_q};
    div_ok    = !div_diff[NB_DATA+1];
  end

  // Sign correction and HI/LO selection, used in FIX
  logic [2*NB_DATA-1:0] prod_fix;
  logic [NB_DATA-1:0]   hi_res, lo_res;

  always_comb begin
    prod_fix = neg_d({acc_q, lo_w_q}, is_signed_q && (sign_a_q ^ sign_b_q));
    if (!is_div_q) begin
      hi_res = prod_fix[2*NB_DATA-1:NB_DATA];
      lo_res = prod_fix[NB_DATA-1:0];
    end else if (dz_q) begin
      hi_res = neg_w(op_a_q, is_signed_q && sign_a_q);
      lo_res = '1;
    end else begin
      hi_res = neg_w(acc_q, is_signed_q && sign_a_q);
      lo_res = neg_w(lo_w_q, is_signed_q && (sign_a_q ^ sign_b_q));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = accept ? RUN : IDLE;
      RUN: begin
        if (bus.i_flush)       state_d = IDLE;
        else if (cnt_q == '0)  state_d = FIX;
      end
      FIX:     state_d = bus.i_flush ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept)
        cnt_q <= NB_CNT'(NB_DATA-1);
      else if (state_q == RUN && cnt_q != '0)
        cnt_q <= cnt_q - 1'b1;
      if (state_q == FIX && !bus.i_flush) begin
        hi_q <= hi_res;
        lo_q <= lo_res;
      end else if (mt_ok && bus.i_funct == F_MTHI) begin
        hi_q <= bus.i_data_1;
      end else if (mt_ok && bus.i_funct == F_MTLO) begin
        lo_q <= bus.i_data_1;
      end
    end
  end

  // Working registers carry no reset; the FSM qualifies every use of them
  always_ff @(posedge i_clk) begin
    if (accept) begin
      op_a_q      <= neg_w(bus.i_data_1, in_sign_a);
      op_b_q      <= neg_w(bus.i_data_2, in_sign_b);
      sign_a_q    <= in_sign_a;
      sign_b_q    <= in_sign_b;
      is_signed_q <= in_signed;
      is_div_q    <= bus.i_funct[1];
      dz_q        <= bus.i_funct[1] && (bus.i_data_2 == '0);
      acc_q       <= '0;
      lo_w_q      <= bus.i_funct[1] ? neg_w(bus.i_data_1, in_sign_a)
                                    : neg_w(bus.i_data_2, in_sign_b);
    end else if (state_q == RUN) begin
      if (is_div_q) begin
        acc_q  <= div_ok ? div_diff[NB_DATA-1:0] : div_trial[NB_DATA-1:0];
        lo_w_q <= {lo_w_q[NB_DATA-2:0], div_ok};
      end else begin
        acc_q  <= mul_sum[NB_DATA:1];
        lo_w_q <= {mul_sum[0], lo_w_q[NB_DATA-1:1]};
      end
    end
  end

  always_comb begin
    bus.o_busy        = (state_q == RUN) || (state_q == FIX);
    bus.o_stall       = bus.o_busy && bus.i_valid && is_hilo;
    bus.o_done        = (state_q == DONE);
    bus.o_div_by_zero = (state_q == DONE) && dz_q;
    bus.o_hi          = hi_q;
    bus.o_lo          = lo_q;
  end
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed and random checks of the HI/LO sequencer against a 64-bit arithmetic model.
module tb_ex_muldiv_ctrl;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_ctrl_if #(.NB_DATA(32), .NB_FUNCT(6)) bus ();
  ex_muldiv_ctrl #(.NB_DATA(32), .NB_FUNCT(6)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_dz = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference results straight from integer arithmetic
  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (f)
      F_MULTU: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      F_MULT:  begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      F_DIVU: begin
        if (b == 0) begin dz = 1'b1; hi = a; lo = '1; end
        else begin lo = a / b; hi = a % b; end
      end
      default: begin
        if (b == 0) begin dz = 1'b1; hi = a; lo = '1; end
        else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
      end
    endcase
  endfunction

  // mode 0: plain op; 1: MFHI held while busy; 2: MTLO held while busy
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int mode);
    int lat;
    bus.i_valid  = 1'b1;
    bus.i_funct  = f;
    bus.i_data_1 = a;
    bus.i_data_2 = b;
    model(f, a, b, m_hi, m_lo, m_dz);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        if (mode == 0) bus.i_valid = 1'b0;
        else begin
          bus.i_funct  = (mode == 1) ? F_MFHI : F_MTLO;
          bus.i_data_1 = 32'hDEAD_BEEF;
        end
      end
      if (bus.o_done) begin lat = n; break; end
      chk("busy_run", 64'(bus.o_busy), 64'd1);
      if (mode != 0) begin
        chk("stall_run", 64'(bus.o_stall), 64'd1);
        if (n == 33) bus.i_valid = 1'b0;
      end
    end
    chk("latency", 64'(lat), 64'd34);
    chk("busy_done", 64'(bus.o_busy), 64'd0);
    chk("hi", 64'(bus.o_hi), 64'(m_hi));
    chk("lo", 64'(bus.o_lo), 64'(m_lo));
    chk("dbz", 64'(bus.o_div_by_zero), 64'(m_dz));
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  typedef struct { logic [5:0] f; logic [31:0] a, b, hi, lo; } vec_t;
  vec_t dvec[8];

  initial begin
    logic [31:0] save_hi, save_lo;
    logic [5:0]  fr;
    bus.i_valid = 1'b0; bus.i_funct = '0; bus.i_data_1 = '0; bus.i_data_2 = '0; bus.i_flush = 1'b0;

    dvec[0] = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    dvec[1] = '{F_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
    dvec[2] = '{F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
    dvec[3] = '{F_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    dvec[4] = '{F_DIVU,  32'd7,         32'd2,         32'd1,         32'd3};
    dvec[5] = '{F_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    dvec[6] = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    dvec[7] = '{F_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", 64'(bus.o_hi), 64'd0);
    chk("rst_lo", 64'(bus.o_lo), 64'd0);
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_done", 64'(bus.o_done), 64'd0);
    chk("rst_dbz", 64'(bus.o_div_by_zero), 64'd0);
    rst_n = 1'b1;

    bus.i_valid = 1'b1; bus.i_funct = F_MTHI; bus.i_data_1 = 32'h1234;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    chk("mthi_hi", 64'(bus.o_hi), 64'h1234);
    chk("mthi_lo", 64'(bus.o_lo), 64'h0);
    chk("mthi_stall", 64'(bus.o_stall), 64'd0);

    for (int i = 0; i < 8; i++) begin
      run_op(dvec[i].f, dvec[i].a, dvec[i].b, (i == 0) ? 1 : ((i == 4) ? 2 : 0));
      chk("vec_hi", 64'(bus.o_hi), 64'(dvec[i].hi));
      chk("vec_lo", 64'(bus.o_lo), 64'(dvec[i].lo));
      chk("vec_dbz", 64'(bus.o_div_by_zero), 64'(i == 7));
    end
    @(posedge clk); #1;
    chk("done_pulse", 64'(bus.o_done), 64'd0);

    // Flush in the middle of a multiply
    save_hi = bus.o_hi; save_lo = bus.o_lo;
    bus.i_valid = 1'b1; bus.i_funct = F_MULT; bus.i_data_1 = 32'd9; bus.i_data_2 = 32'd9;
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk); #1;
      if (n == 1) bus.i_valid = 1'b0;
      if (n == 10) bus.i_flush = 1'b1;
      if (n == 11) begin
        chk("flush_busy", 64'(bus.o_busy), 64'd0);
        bus.i_flush = 1'b0;
      end
      if (n > 11 && bus.o_done) chk("flush_done", 64'(bus.o_done), 64'd0);
    end
    chk("flush_hi", 64'(bus.o_hi), 64'(save_hi));
    chk("flush_lo", 64'(bus.o_lo), 64'(save_lo));

    // Reset in the middle of a divide
    bus.i_valid = 1'b1; bus.i_funct = F_DIVU; bus.i_data_1 = 32'd100; bus.i_data_2 = 32'd7;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
      if (n == 1) bus.i_valid = 1'b0;
      if (n == 5) rst_n = 1'b0;
    end
    chk("mrst_hi", 64'(bus.o_hi), 64'd0);
    chk("mrst_lo", 64'(bus.o_lo), 64'd0);
    chk("mrst_busy", 64'(bus.o_busy), 64'd0);
    rst_n = 1'b1;

    // Random ops, some back-to-back from the DONE cycle
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: fr = F_MULT;
        1: fr = F_MULTU;
        2: fr = F_DIV;
        default: fr = F_DIVU;
      endcase
      run_op(fr, rnd_operand(), rnd_operand(), 0);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        chk("rnd_done_pulse", 64'(bus.o_done), 64'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
